// File: rtl/lane_pipe_scheduler.sv
// Round-robin scheduler that shares one fixed-latency 2-bit lane among N_REQ requesters.
// It tags each accepted item with its owner and returns the lane result to that owner.
module lane_pipe_scheduler #(
  parameter int N_REQ = 6,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [2*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               pipe_v,
  output logic [1:0]         pipe_i,
  input  logic [1:0]         pipe_o,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [1:0]         rsp_data,
  output logic [3:0]         inflight,
  output logic               busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  // Handshake: requester i transfers in any cycle where req_valid[i] && req_ready[i];
  // req_ready is combinational, one-hot, and never high for a requester still pending.

  logic [N_REQ-1:0]            pending_q, pending_d;
  logic [IDX_W-1:0]            ptr_q, ptr_d;
  logic [DEPTH:0]              tag_v_q, tag_v_d;
  logic [DEPTH:0][IDX_W-1:0]   tag_idx_q, tag_idx_d;
  logic [1:0]                  pipe_i_q, pipe_i_d;
  logic [N_REQ-1:0]            rsp_valid_q, rsp_valid_d;
  logic [1:0]                  rsp_data_q, rsp_data_d;
  logic [3:0]                  inflight_q, inflight_d;

  logic [N_REQ-1:0]            eligible;
  logic [N_REQ-1:0]            grant;
  logic [IDX_W-1:0]            gidx;
  logic [IDX_W-1:0]            cand_idx;
  logic                        xfer;

  // Round-robin search starts one past the last granted index and wraps.
  always_comb begin
    eligible = req_valid & ~pending_q & {N_REQ{en & rst_n}};
    grant    = '0;
    gidx     = ptr_q;
    cand_idx = '0;
    xfer     = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand_idx = IDX_W'((int'(ptr_q) + off) % N_REQ);
      if (!xfer && eligible[cand_idx]) begin
        xfer  = 1'b1;
        gidx  = cand_idx;
        grant = N_REQ'(1) << cand_idx;
      end
    end
  end

  always_comb begin
    pipe_i_d = pipe_i_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) pipe_i_d = req_data[2*i +: 2];
    end

    // Stage 0 sits alongside pipe_v; stage DEPTH lines up with pipe_o.
    tag_v_d      = '0;
    tag_idx_d    = '0;
    tag_v_d[0]   = xfer;
    tag_idx_d[0] = gidx;
    for (int s = 1; s <= DEPTH; s++) begin
      tag_v_d[s]   = tag_v_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end

    rsp_valid_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid_d[i] = tag_v_q[DEPTH] && (tag_idx_q[DEPTH] == IDX_W'(i));
    end
    rsp_data_d = tag_v_q[DEPTH] ? pipe_o : rsp_data_q;

    // Clearing on the edge that raises rsp_valid lets the owner re-request in that same cycle.
    pending_d = (pending_q | grant) & ~rsp_valid_d;
    ptr_d     = xfer ? gidx : ptr_q;

    // An item stops counting once its response cycle has been presented.
    inflight_d = inflight_q + {3'b000, xfer} - {3'b000, |rsp_valid_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      ptr_q       <= LAST_IDX;
      tag_v_q     <= '0;
      tag_idx_q   <= '0;
      pipe_i_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      inflight_q  <= '0;
    end else begin
      pending_q   <= pending_d;
      ptr_q       <= ptr_d;
      tag_v_q     <= tag_v_d;
      tag_idx_q   <= tag_idx_d;
      pipe_i_q    <= pipe_i_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      inflight_q  <= inflight_d;
    end
  end

  assign req_ready = grant;
  assign pipe_v    = tag_v_q[0];
  assign pipe_i    = pipe_i_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign inflight  = inflight_q;
  assign busy      = |inflight_q;

endmodule

// File: tb/tb_lane_pipe_scheduler.sv
// Directed bench for lane_pipe_scheduler: identity lane model of DEPTH stages,
// hand-computed expectations checked with immediate assertions.
module tb_lane_pipe_scheduler;

  localparam int N = 6;
  localparam int D = 4;

  logic           clk;
  logic           rst_n;
  logic           en;
  logic [N-1:0]   req_valid;
  logic [2*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           pipe_v;
  logic [1:0]     pipe_i;
  logic [1:0]     pipe_o;
  logic [N-1:0]   rsp_valid;
  logic [1:0]     rsp_data;
  logic [3:0]     inflight;
  logic           busy;

  logic [1:0] lane_q [D];
  logic [1:0] pay [N];

  int n_cmp;
  int n_err;

  lane_pipe_scheduler #(.N_REQ(N), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .pipe_v    (pipe_v),
    .pipe_i    (pipe_i),
    .pipe_o    (pipe_o),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .inflight  (inflight),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // lane: pipe_i seen in cycle c comes back on pipe_o in cycle c+D
  always @(posedge clk) begin
    lane_q[0] <= pipe_i;
    for (int k = 1; k < D; k++) lane_q[k] <= lane_q[k-1];
  end
  assign pipe_o = lane_q[D-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_pipe_v"},    32'(pipe_v),    32'd0);
    chk({tag, "_pipe_i"},    32'(pipe_i),    32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
    chk({tag, "_inflight"},  32'(inflight),  32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  task automatic reset_pulse();
    rst_n     = 1'b0;
    req_valid = '0;
    en        = 1'b1;
    tick();
    rst_n     = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    pay[0] = 2'b10; pay[1] = 2'b11; pay[2] = 2'b01;
    pay[3] = 2'b10; pay[4] = 2'b00; pay[5] = 2'b11;
    for (int i = 0; i < N; i++) req_data[2*i +: 2] = pay[i];

    // reset state, with every requester asking
    rst_n     = 1'b0;
    en        = 1'b1;
    req_valid = '1;
    tick();
    tick();
    chk_reset("por");
    rst_n     = 1'b1;
    req_valid = '0;

    // single request from requester 0
    req_valid = 6'b000001;
    #1;
    chk("single_ready", 32'(req_ready), 32'h01);
    tick();
    req_valid = '0;
    chk("single_pipe_v",   32'(pipe_v),    32'd1);
    chk("single_pipe_i",   32'(pipe_i),    32'(2'b10));
    chk("single_inflight", 32'(inflight),  32'd1);
    chk("single_busy",     32'(busy),      32'd1);
    for (int c = 1; c <= D; c++) begin
      tick();
      chk("single_wait_rsp",  32'(rsp_valid), 32'd0);
      chk("single_pipe_v_lo", 32'(pipe_v),    32'd0);
      chk("single_pipe_i_hold", 32'(pipe_i),  32'(2'b10));
    end
    tick();
    chk("single_rsp_valid", 32'(rsp_valid), 32'h01);
    chk("single_rsp_data",  32'(rsp_data),  32'(2'b10));
    chk("single_inflight_rsp", 32'(inflight), 32'd1);
    tick();
    chk("single_rsp_done",  32'(rsp_valid), 32'd0);
    chk("single_inflight0", 32'(inflight),  32'd0);
    chk("single_busy0",     32'(busy),      32'd0);

    // all six requesting continuously
    reset_pulse();
    req_valid = '1;
    #1;
    for (int j = 0; j < N; j++) begin
      chk("rr_grant", 32'(req_ready), 32'(1) << j);
      tick();
      chk("rr_pipe_v",   32'(pipe_v),   32'd1);
      chk("rr_pipe_i",   32'(pipe_i),   32'(pay[j]));
      chk("rr_inflight", 32'(inflight), 32'(j + 1));
    end
    for (int j = 0; j < N; j++) begin
      chk("rr_rsp_valid",  32'(rsp_valid), 32'(1) << j);
      chk("rr_rsp_data",   32'(rsp_data),  32'(pay[j]));
      chk("rr_regrant",    32'(req_ready), 32'(1) << j);
      chk("rr_inflight6",  32'(inflight),  32'd6);
      tick();
    end

    // grant enable low with three items in flight
    reset_pulse();
    req_valid = 6'b000111;
    #1;
    tick();
    tick();
    tick();
    chk("en_inflight3", 32'(inflight), 32'd3);
    en        = 1'b0;
    req_valid = '1;
    #1;
    chk("en_no_ready_a3", 32'(req_ready), 32'd0);
    tick();
    chk("en_no_ready_a4", 32'(req_ready), 32'd0);
    tick();
    tick();
    chk("en_rsp0",      32'(rsp_valid), 32'h01);
    chk("en_rsp0_data", 32'(rsp_data),  32'(pay[0]));
    chk("en_no_ready_a6", 32'(req_ready), 32'd0);
    tick();
    chk("en_rsp1",      32'(rsp_valid), 32'h02);
    chk("en_rsp1_data", 32'(rsp_data),  32'(pay[1]));
    chk("en_inflight2", 32'(inflight),  32'd2);
    tick();
    chk("en_rsp2",      32'(rsp_valid), 32'h04);
    chk("en_rsp2_data", 32'(rsp_data),  32'(pay[2]));
    chk("en_inflight1", 32'(inflight),  32'd1);
    chk("en_busy1",     32'(busy),      32'd1);
    tick();
    chk("en_rsp_none",  32'(rsp_valid), 32'd0);
    chk("en_inflight0", 32'(inflight),  32'd0);
    chk("en_busy0",     32'(busy),      32'd0);
    en = 1'b1;
    #1;
    chk("en_resume_ptr", 32'(req_ready), 32'h08);
    tick();
    chk("en_resume_pipe_v", 32'(pipe_v), 32'd1);
    chk("en_resume_pipe_i", 32'(pipe_i), 32'(pay[3]));

    // transfer from 2 in the cycle requester 5 gets its response
    reset_pulse();
    req_valid = 6'b100000;
    #1;
    chk("sim_grant5", 32'(req_ready), 32'h20);
    tick();
    req_valid = '0;
    repeat (D) tick();
    tick();
    chk("sim_rsp5",      32'(rsp_valid), 32'h20);
    chk("sim_rsp5_data", 32'(rsp_data),  32'(pay[5]));
    chk("sim_inflight_before", 32'(inflight), 32'd1);
    req_valid = 6'b000100;
    #1;
    chk("sim_grant2", 32'(req_ready), 32'h04);
    tick();
    chk("sim_inflight_same", 32'(inflight), 32'd1);
    chk("sim_pipe_i2",       32'(pipe_i),   32'(pay[2]));
    chk("sim_rsp_clear",     32'(rsp_valid), 32'd0);
    #1;
    chk("sim_pending2", 32'(req_ready), 32'd0);
    req_valid = 6'b100100;
    #1;
    chk("sim_free5", 32'(req_ready), 32'h20);
    req_valid = '0;

    // reset pulse with four items in flight
    reset_pulse();
    req_valid = 6'b001111;
    #1;
    repeat (4) tick();
    req_valid = '0;
    chk("mid_inflight4", 32'(inflight), 32'd4);
    rst_n     = 1'b0;
    req_valid = '1;
    #1;
    chk_reset("mid_rst");
    tick();
    rst_n     = 1'b1;
    req_valid = '0;
    for (int c = 0; c < D + 2; c++) begin
      tick();
      chk("mid_no_rsp",      32'(rsp_valid), 32'd0);
      chk("mid_inflight_lo", 32'(inflight),  32'd0);
    end
    req_valid = '1;
    #1;
    chk("mid_first_grant", 32'(req_ready), 32'h01);
    req_valid = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
